add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; even, >= 4.
REQ-002 SHALL have parameter SAT, default 0; 1 = saturate on overflow, 0 = wrap.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_in, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, operands valid.
REQ-007 SHALL have port ready_out, output, 1, block accepts operands.
REQ-008 SHALL have ports a_in and b_in, input, WIDTH each, operands.
REQ-009 SHALL have port sub_in, input, 1, 0 = a+b, 1 = a-b.
REQ-010 SHALL have port signed_in, input, 1, two's-complement interpretation.
REQ-011 SHALL have port valid_out, output, 1, result valid.
REQ-012 SHALL have port ready_in, input, 1, downstream accepts result.
REQ-013 SHALL have port sum_out, output, WIDTH, result.
REQ-014 SHALL have port carry_out, output, 1, raw MSB carry.
REQ-015 SHALL have port ovf_out, output, 1, overflow.
REQ-016 SHALL have port zero_out, output, 1, sum_out == 0.
REQ-017 SHALL have port neg_out, output, 1, negative result.

Function
REQ-018 SHALL compute raw = a_in + (sub_in ? ~b_in : b_in) + sub_in, WIDTH+1 bits; carry_out = raw[WIDTH].
REQ-019 SHALL split the carry chain: stage 1 computes the low WIDTH/2 bits and registers the inter-half carry; stage 2 computes the high half from that registered carry.
REQ-020 SHALL carry sub_in, signed_in, and the upper operand halves alongside stage 1 data.
REQ-021 SHALL give a latency of 2 cycles from acceptance (valid_in && ready_out at an edge) to valid_out when not stalled; throughput SHALL be one result per cycle.
REQ-022 SHALL transfer a result on valid_out && ready_in; while valid_out && !ready_in, all outputs SHALL hold stable.
REQ-023 SHALL load stage 2 when it is empty or its result is taken; stage 1 SHALL load when it is empty or moves into stage 2.
REQ-024 SHALL drive ready_out = !s1_valid || !valid_out || ready_in, combinationally from register state and ready_in only.
REQ-025 SHALL deliver results in acceptance order with no loss or duplication; simultaneous accept and drain SHALL both occur.
REQ-026 SHALL compute ovf_out as follows:
- unsigned add: carry.
- unsigned sub: !carry (borrow).
- signed: operand signs equal (after b inversion) and result sign differs.
REQ-027 SHALL, when SAT=1 and ovf, clamp sum_out:
- unsigned add: all ones.
- unsigned sub: 0.
- signed positive overflow: 0 then ones (max positive).
- signed negative overflow: 1 then zeros (min negative).
REQ-028 SHALL leave carry_out and ovf_out unaffected by saturation.
REQ-029 SHALL compute zero_out from the final (post-saturation) sum_out.
REQ-030 SHALL drive neg_out = sum_out[WIDTH-1] && signed_in.
REQ-031 SHALL ignore operand, sub_in and signed_in values when valid_in = 0.

Reset
REQ-032 SHALL, while rst_n_in = 0, clear both stage valid flags immediately, independent of clk_in.
REQ-033 SHALL hold valid_out = 0, sum_out = 0, carry_out = 0, ovf_out = 0, neg_out = 0 and zero_out = 1 while in reset.
REQ-034 SHALL hold ready_out = 1 during reset and in the first cycle after release.
REQ-035 SHALL discard in-flight data on reset mid-operation; no stale result SHALL appear after release.

Verification (WIDTH=8)
REQ-036 Unsigned add 0xF0+0x20, SAT=0 -> after 2 cycles sum 0x10, carry 1, ovf 1; with SAT=1 -> sum 0xFF, carry 1, ovf 1.
REQ-037 Unsigned sub 0x05-0x07 -> sum 0xFE, carry 0, ovf 1; with SAT=1 -> sum 0x00, zero 1.
REQ-038 Signed add 0x7F+0x01 -> sum 0x80, ovf 1, neg 1; with SAT=1 -> sum 0x7F, neg 0. Signed sub 0x80-0x01 with SAT=1 -> sum 0x80, ovf 1.
REQ-039 Inter-half carry: 0x0F+0x01 -> 0x10, carry 0; 0xFF+0x01 -> 0x00, carry 1, zero 1; sub 0x10-0x01 -> 0x0F, carry 1.
REQ-040 Backpressure: 4 back-to-back inputs with ready_in = 0 for 4 cycles -> ready_out falls after 2 accepts, outputs stay stable, then all 4 results emerge in order, each exactly once.
REQ-041 Reset asserted mid-clock with both stages full -> valid_out 0 before the next edge; after release no result appears until new input is accepted.

Source files
------------

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined adder/subtractor with a valid/ready handshake.
// The carry chain is split: stage 1 adds the low half and registers the
// inter-half carry, stage 2 adds the high half and forms flags and
// optional saturation. Only the valid flags are reset; data registers
// are masked at the outputs while no result is valid.
module add_sub_pipe #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  input  logic             signed_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic             zero_out,
  output logic             neg_out
);

  localparam int HALF = WIDTH / 2;

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("add_sub_pipe: WIDTH must be even and at least 4");
  end

  // Overflow: signed uses operand/result sign rule, unsigned uses carry/borrow.
  function automatic logic calc_ovf(input logic sgn, input logic sub,
                                    input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic cy);
    if (sgn)
      return (a_msb == b_msb) && (r_msb != a_msb);
    else if (sub)
      return !cy;
    else
      return cy;
  endfunction

  // Clamp the wrapped result to the representable limit on overflow.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                input logic ovf, input logic sgn,
                                                input logic sub, input logic a_msb);
    if (SAT == 1'b0 || !ovf)
      return r;
    if (sgn)
      return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
  endfunction

  logic             vld_p1, vld_p2;
  logic             ld_p1, ld_p2;

  logic [HALF-1:0]  lo_p1;
  logic             cy_p1;
  logic [HALF-1:0]  a_hi_p1;
  logic [HALF-1:0]  b_hi_p1;
  logic             sub_p1;
  logic             sgn_p1;

  logic [WIDTH-1:0] sum_p2;
  logic             carry_p2;
  logic             ovf_p2;
  logic             sgn_p2;

  logic [WIDTH-1:0] b_eff;
  logic [HALF:0]    lo_raw;
  logic [HALF:0]    hi_raw;
  logic [WIDTH:0]   raw;
  logic             ovf_c;

  // Stage 2 frees up when empty or its result is taken; stage 1 when it
  // is empty or can advance into stage 2.
  assign ld_p2     = !vld_p2 || ready_in;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign ready_out = !vld_p1 || !vld_p2 || ready_in;

  // ---- stage 0 -> 1: low half of the carry chain ----
  assign b_eff  = sub_in ? ~b_in : b_in;
  assign lo_raw = {1'b0, a_in[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]}
                + {{HALF{1'b0}}, sub_in};

  // ---- stage 1 -> 2: high half, flags and saturation ----
  assign hi_raw = {1'b0, a_hi_p1} + {1'b0, b_hi_p1} + {{HALF{1'b0}}, cy_p1};
  assign raw    = {hi_raw, lo_p1};
  assign ovf_c  = calc_ovf(sgn_p1, sub_p1, a_hi_p1[HALF-1], b_hi_p1[HALF-1],
                           raw[WIDTH-1], raw[WIDTH]);

  // Valid flags: cleared asynchronously, advance with the load enables.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p1) vld_p1 <= valid_in;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 data: low-half sum, inter-half carry and the operands' upper halves.
  always_ff @(posedge clk_in) begin
    if (ld_p1 && valid_in) begin
      lo_p1   <= lo_raw[HALF-1:0];
      cy_p1   <= lo_raw[HALF];
      a_hi_p1 <= a_in[WIDTH-1:HALF];
      b_hi_p1 <= b_eff[WIDTH-1:HALF];
      sub_p1  <= sub_in;
      sgn_p1  <= signed_in;
    end
  end

  // Stage 2 data: final result, raw carry and overflow.
  always_ff @(posedge clk_in) begin
    if (ld_p2 && vld_p1) begin
      sum_p2   <= saturate(raw[WIDTH-1:0], ovf_c, sgn_p1, sub_p1, a_hi_p1[HALF-1]);
      carry_p2 <= raw[WIDTH];
      ovf_p2   <= ovf_c;
      sgn_p2   <= sgn_p1;
    end
  end

  // Outputs read as zero (zero_out = 1) whenever no result is held.
  assign valid_out = vld_p2;
  assign sum_out   = vld_p2 ? sum_p2 : {WIDTH{1'b0}};
  assign carry_out = vld_p2 && carry_p2;
  assign ovf_out   = vld_p2 && ovf_p2;
  assign zero_out  = (sum_out == {WIDTH{1'b0}});
  assign neg_out   = vld_p2 && sgn_p2 && sum_out[WIDTH-1];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: a wrapping and a saturating instance share
// stimulus; a behavioural model fills per-instance scoreboards.
module tb_add_sub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in, ready_in, sub_in, signed_in;
  logic [7:0] a_in, b_in;

  logic       rdy_w, vld_w, c_w, o_w, z_w, n_w;
  logic       rdy_s, vld_s, c_s, o_s, z_s, n_s;
  logic [7:0] sum_w, sum_s;

  int errors = 0;
  int checks = 0;

  logic [11:0] q [2][$];
  logic        stall [2];
  logic [11:0] held  [2];
  bit          done;

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(8), .SAT(1'b0)) u_wrap (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(rdy_w),
    .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .signed_in(signed_in),
    .valid_out(vld_w), .ready_in(ready_in), .sum_out(sum_w),
    .carry_out(c_w), .ovf_out(o_w), .zero_out(z_w), .neg_out(n_w));

  add_sub_pipe #(.WIDTH(8), .SAT(1'b1)) u_sat (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(rdy_s),
    .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .signed_in(signed_in),
    .valid_out(vld_s), .ready_in(ready_in), .sum_out(sum_s),
    .carry_out(c_s), .ovf_out(o_s), .zero_out(z_s), .neg_out(n_s));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Packed expectation {sum[7:0], carry, ovf, zero, neg} from integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input logic g, input bit sat);
    int ua, ub, full, sa, sb, sres;
    logic [7:0] sum;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    full = s ? (ua + (255 - ub) + 1) : (ua + ub);
    c = (full > 255);
    sum = 8'(full);
    sres = s ? (sa - sb) : (sa + sb);
    if (g) o = (sres > 127) || (sres < -128);
    else   o = s ? (ua < ub) : (ua + ub > 255);
    if (sat && o) begin
      if (g) sum = (sres > 127) ? 8'h7F : 8'h80;
      else   sum = s ? 8'h00 : 8'hFF;
    end
    return {sum, c, o, (sum == 8'h00), (g && sum[7])};
  endfunction

  task automatic mon(input int k, input logic rdy, input logic vld, input logic [11:0] obs);
    logic [11:0] e;
    string sfx;
    sfx = (k == 0) ? "_wrap" : "_sat";
    if (!rst_n) begin
      q[k].delete();
      stall[k] = 1'b0;
      return;
    end
    if (stall[k]) chk({"hold", sfx}, 32'({vld, obs}), 32'({1'b1, held[k]}));
    if (vld && ready_in) begin
      if (q[k].size() == 0) chk({"extra_out", sfx}, 32'(1), 32'(0));
      else begin
        e = q[k].pop_front();
        chk({"result", sfx}, 32'(obs), 32'(e));
      end
    end
    if (valid_in && rdy) q[k].push_back(model(a_in, b_in, sub_in, signed_in, k[0]));
    stall[k] = vld && !ready_in;
    held[k]  = obs;
  endtask

  // Handshakes are evaluated mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    mon(0, rdy_w, vld_w, {sum_w, c_w, o_w, z_w, n_w});
    mon(1, rdy_s, vld_s, {sum_s, c_s, o_s, z_s, n_s});
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic g);
    int waited;
    waited = 0;
    a_in = a; b_in = b; sub_in = s; signed_in = g; valid_in = 1'b1;
    @(negedge clk);
    while (!rdy_w) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", 32'(waited), 32'(0));
        valid_in = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_in = 1'b1;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(n < 50), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'({vld_w, vld_s}), 32'(0));
    chk({tag, "_outs_wrap"}, 32'({sum_w, c_w, o_w, z_w, n_w}), 32'(12'h002));
    chk({tag, "_outs_sat"},  32'({sum_s, c_s, o_s, z_s, n_s}), 32'(12'h002));
    chk({tag, "_ready"}, 32'({rdy_w, rdy_s}), 32'(2'b11));
  endtask

  logic [7:0] va [10] = '{8'hF0, 8'h05, 8'h7F, 8'h80, 8'h0F, 8'hFF, 8'h10, 8'h00, 8'hFF, 8'h00};
  logic [7:0] vb [10] = '{8'h20, 8'h07, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h00};
  logic       vs [10] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
  logic       vg [10] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    sub_in = 1'b0; signed_in = 1'b0; a_in = 8'h00; b_in = 8'h00;
    done = 1'b0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    held[0] = '0; held[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'({rdy_w, rdy_s}), 32'(2'b11));
    @(posedge clk); #1;

    // Directed corner cases, back to back.
    for (int i = 0; i < 10; i++) send(va[i], vb[i], vs[i], vg[i]);
    drain();

    // Backpressure: four inputs against a stalled sink.
    ready_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'(i * 16 + 1), 8'h03, 1'b0, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        chk("bp_ready_low", 32'({rdy_w, rdy_s}), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset mid-cycle with both stages full.
    ready_in = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b0);
    chk("full_before_reset", 32'({vld_w, rdy_w}), 32'(2'b10));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'({vld_w, vld_s}), 32'(0));
    send(8'h12, 8'h34, 1'b0, 1'b0);
    drain();

    chk("queues_empty", 32'(q[0].size() + q[1].size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
